dmem_arbiter: RTL

//   Shares one single-port data memory (async read, write on posedge clk, word

---
 rtl/dmem_arbiter_pkg.sv | 20 ++
 rtl/dmem_arbiter_rr_arb2.sv | 37 +++
 rtl/dmem_arbiter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared owner-state encoding and port indices for dmem_arbiter
// Purpose: types and constants shared by dmem_arbiter and its rr_arb2 grant logic.
// Contents: owner_t (OWN_NONE / OWN_0 / OWN_1), port index constants.
package dmem_arbiter_pkg;

    // Which port currently holds a burst lock on the memory.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_0    = 2'd1,
        OWN_1    = 2'd2
    } owner_t;

    localparam int PORT0 = 0;
    localparam int PORT1 = 1;

    // Value of the "last granted" flag after a grant to each port.
    localparam logic LAST_P0 = 1'b0;
    localparam logic LAST_P1 = 1'b1;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// rtl/dmem_arbiter_rr_arb2.sv - two-way round-robin grant with burst owner override
// Purpose: combinational one-hot grant for two requesters.
// Ports:
//   req0, req1   in   request lines
//   last         in   port granted most recently (1 = port 1)
//   owner        in   current burst owner; an owner with its request high wins outright
//   gnt0, gnt1   out  grant, never both high
module rr_arb2
    import dmem_arbiter_pkg::*;
(
    input  logic   req0,
    input  logic   req1,
    input  logic   last,
    input  owner_t owner,
    output logic   gnt0,
    output logic   gnt1
);

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (owner == OWN_0 && req0) begin
            gnt0 = 1'b1;
        end else if (owner == OWN_1 && req1) begin
            gnt1 = 1'b1;
        end else if (req0 && req1) begin
            // Tie: the port that did not win last time goes first.
            if (last == LAST_P1) gnt0 = 1'b1;
            else                 gnt1 = 1'b1;
        end else begin
            // An owner that dropped its request no longer blocks the other port.
            gnt0 = req0;
            gnt1 = req1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port arbiter in front of a single-port data memory
// Purpose: shares one async-read / sync-write dmem between the CPU LSU (port 0)
//   and the loader/debug port (port 1) with round-robin arbitration, burst lock,
//   misalignment drop and registered read return.
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   reqN, weN, lockN       request, write enable, keep-grant (burst) per port
//   aN, wdN                byte address (word aligned) and write data per port
//   gntN                   combinational grant
//   rvalidN, rdN           read return, one cycle after a read grant
//   errN                   one-cycle pulse after a misaligned request is dropped
//   mem_we, mem_a, mem_wd  to dmem;  mem_rd from dmem
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int LOCK_MAX = 16,
    parameter int CNT_W    = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic        lock0,
    input  logic        lock1,
    input  logic [31:0] a0,
    input  logic [31:0] a1,
    input  logic [31:0] wd0,
    input  logic [31:0] wd1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        rvalid0,
    output logic        rvalid1,
    output logic [31:0] rd0,
    output logic [31:0] rd1,
    output logic        err0,
    output logic        err1,
    output logic        mem_we,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    owner_t             owner;
    logic               last;
    logic [CNT_W-1:0]   lock_cnt;

    logic               arb_g0;
    logic               arb_g1;
    logic               aligned0;
    logic               aligned1;
    logic               g_lock;
    logic               g_same;
    logic [CNT_W-1:0]   run_next;

    rr_arb2 u_rr_arb2 (
        .req0  (req0),
        .req1  (req1),
        .last  (last),
        .owner (owner),
        .gnt0  (arb_g0),
        .gnt1  (arb_g1)
    );

    // No grant may be issued while reset is held.
    assign gnt0     = arb_g0 & ~reset;
    assign gnt1     = arb_g1 & ~reset;
    assign aligned0 = (a0[1:0] == 2'b00);
    assign aligned1 = (a1[1:0] == 2'b00);

    always_comb begin
        mem_we = 1'b0;
        mem_a  = 32'h0;
        mem_wd = 32'h0;
        if (gnt0) begin
            mem_we = we0 & aligned0;
            mem_a  = a0;
            mem_wd = wd0;
        end else if (gnt1) begin
            mem_we = we1 & aligned1;
            mem_a  = a1;
            mem_wd = wd1;
        end
    end

    // Length of the locked run including this grant; a grant to a port that
    // does not already own the memory starts a fresh run.
    always_comb begin
        g_lock   = gnt0 ? lock0 : lock1;
        g_same   = (gnt0 && owner == OWN_0) || (gnt1 && owner == OWN_1);
        run_next = g_same ? lock_cnt + 1'b1 : CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            owner    <= OWN_NONE;
            last     <= LAST_P1;
            lock_cnt <= '0;
            rvalid0  <= 1'b0;
            rvalid1  <= 1'b0;
            rd0      <= 32'h0;
            rd1      <= 32'h0;
            err0     <= 1'b0;
            err1     <= 1'b0;
        end else begin
            if (gnt0 || gnt1) begin
                last <= gnt1;
                // Reaching LOCK_MAX completes this grant but releases the lock;
                // since last now points at the owner, the other port wins next.
                if (g_lock && run_next < CNT_W'(LOCK_MAX)) begin
                    owner    <= gnt0 ? OWN_0 : OWN_1;
                    lock_cnt <= run_next;
                end else begin
                    owner    <= OWN_NONE;
                    lock_cnt <= '0;
                end
            end else begin
                owner    <= OWN_NONE;
                lock_cnt <= '0;
            end

            rvalid0 <= gnt0 & ~we0 & aligned0;
            rvalid1 <= gnt1 & ~we1 & aligned1;
            if (gnt0 & ~we0 & aligned0) rd0 <= mem_rd;
            if (gnt1 & ~we1 & aligned1) rd1 <= mem_rd;
            err0 <= gnt0 & ~aligned0;
            err1 <= gnt1 & ~aligned1;
        end
    end

endmodule
